// File: rtl/tilt_led_bar.sv
// -----------------------------------------------------------------------------
// tilt_led_bar
//   Accelerometer-tilt LED bar driver. One axis sample is taken on each falling
//   edge of the sensor data-ready line. After power-up or a recalibration
//   request, a settling period is followed by a zero-offset calibration. In RUN
//   the offset-corrected samples pass through a 2**AVG_LOG2 moving average,
//   optional x4 gain with saturation, and a one-hot LED map with a centre dead
//   zone.
//
// Ports
//   iCLK       in   1     system clock
//   iRSTN      in   1     asynchronous active-low reset
//   iDIG       in   DW    raw axis sample, offset binary (mid = 2**(DW-1))
//   iG_INT2    in   1     data-ready, falling edge marks a new sample
//   iRECAL     in   1     single-cycle recalibration request
//   iFINE      in   1     1 = x4 gain, 0 = x1
//   oLED       out  NLED  LED drive, 1 = on
//   oCAL_BUSY  out  1     high while settling or calibrating
//   oLEVEL     out  DW    signed averaged level (before gain)
//   oVALID     out  1     one-cycle pulse when oLED/oLEVEL update in RUN
// -----------------------------------------------------------------------------
module tilt_led_bar #(
    parameter int DW        = 10,
    parameter int AVG_LOG2  = 4,
    parameter int NLED      = 8,
    parameter int CAL_WAIT  = 1252,
    parameter int CAL_LOG2  = 4,
    parameter int DEADZONE  = 16,
    parameter int BLINK_BIT = 9
) (
    input  logic                 iCLK,
    input  logic                 iRSTN,
    input  logic [DW-1:0]        iDIG,
    input  logic                 iG_INT2,
    input  logic                 iRECAL,
    input  logic                 iFINE,
    output logic [NLED-1:0]      oLED,
    output logic                 oCAL_BUSY,
    output logic signed [DW-1:0] oLEVEL,
    output logic                 oVALID
);

    localparam int AVG_N = 2 ** AVG_LOG2;
    localparam int LW    = $clog2(NLED);
    localparam int SW    = DW + AVG_LOG2;   // moving-average sum width
    localparam int CW    = DW + CAL_LOG2;   // calibration accumulator width
    localparam int CCW   = CAL_LOG2 + 1;    // calibration sample counter width

    localparam logic [DW-1:0]        HALF      = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        SAT_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        SAT_MIN   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] DZ_P      = DW'(DEADZONE);
    localparam logic signed [DW-1:0] DZ_N      = -DZ_P;
    localparam logic [15:0]          WAIT_INIT = 16'(CAL_WAIT);
    localparam logic [CCW-1:0]       CAL_N     = CCW'(2 ** CAL_LOG2);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAL,
        ST_RUN
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                 state_q;
    logic                   int_dly_q;
    logic                   strb_q;
    logic [DW-1:0]          dig_q;
    logic [15:0]            wait_cnt_q;
    logic [CCW-1:0]         cal_cnt_q;
    logic signed [CW-1:0]   cal_acc_q;
    logic [DW-1:0]          offset_q;
    logic signed [DW-1:0]   hist_q [AVG_N];
    logic signed [SW-1:0]   sum_q;
    logic                   sum_vld_q;
    logic [NLED-1:0]        led_q;
    logic signed [DW-1:0]   level_q;
    logic                   valid_q;

    // ------------------------------------------------------- combinational
    logic                   fall;
    logic [DW-1:0]          cal_raw;
    logic signed [CW-1:0]   cal_acc_d;
    logic [DW-1:0]          offset_d;
    logic [DW-1:0]          corr_sum;
    logic signed [DW-1:0]   corr_c;
    logic signed [SW-1:0]   sum_d;
    logic signed [DW-1:0]   level_d;
    logic [DW+1:0]          x4;
    logic signed [DW-1:0]   gained;
    logic [LW-1:0]          led_idx;
    logic [NLED-1:0]        led_d;

    assign fall = ~iG_INT2 & int_dly_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        cal_raw   = '0;
        cal_acc_d = '0;
        offset_d  = '0;
        corr_sum  = '0;
        corr_c    = '0;
        sum_d     = '0;
        level_d   = '0;
        x4        = '0;
        gained    = '0;
        led_idx   = '0;
        led_d     = '0;

        // Calibration: distance of the raw sample from mid-scale, wrapped to
        // DW bits and sign-extended into the accumulator.
        cal_raw   = HALF - dig_q;
        cal_acc_d = cal_acc_q + {{CAL_LOG2{cal_raw[DW-1]}}, cal_raw};
        offset_d  = DW'(cal_acc_d >>> CAL_LOG2);

        // Subtracting mid-scale from a DW-bit offset-binary value is the
        // same as inverting its MSB.
        corr_sum  = dig_q + offset_q;
        corr_c    = {~corr_sum[DW-1], corr_sum[DW-2:0]};

        // Running sum: add newest, drop oldest. The sum holds at most AVG_N
        // DW-bit values, so SW bits never overflow.
        sum_d     = sum_q + {{AVG_LOG2{corr_c[DW-1]}}, corr_c}
                          - {{AVG_LOG2{hist_q[AVG_N-1][DW-1]}}, hist_q[AVG_N-1]};
        level_d   = DW'(sum_q >>> AVG_LOG2);

        // x4 fits in DW bits only when the three top bits of the DW+2-bit
        // product agree; otherwise clamp towards the product's sign.
        x4        = {level_d, 2'b00};
        if (x4[DW+1:DW-1] == 3'b000 || x4[DW+1:DW-1] == 3'b111) begin
            gained = x4[DW-1:0];
        end else begin
            gained = x4[DW+1] ? SAT_MIN : SAT_MAX;
        end
        if (!iFINE) begin
            gained = level_d;
        end

        // Bar position: top LW bits of the offset-binary value. With NLED a
        // power of two, NLED-1-idx is just the bitwise inverse of idx.
        led_idx   = {~gained[DW-1], gained[DW-2 -: LW-1]};
        if (gained > DZ_N && gained < DZ_P) begin
            led_d[NLED/2]   = 1'b1;
            led_d[NLED/2-1] = 1'b1;
        end else begin
            led_d[~led_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------ sequential
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q    <= ST_WAIT;
            int_dly_q  <= 1'b0;
            strb_q     <= 1'b0;
            dig_q      <= '0;
            wait_cnt_q <= WAIT_INIT;
            cal_cnt_q  <= '0;
            cal_acc_q  <= '0;
            offset_q   <= '0;
            // NOTE: the history is reset as well, because zeroed entries are
            // meaningful: they stand for centre samples until it fills.
            for (int i = 0; i < AVG_N; i++) begin
                hist_q[i] <= '0;
            end
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            led_q      <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            int_dly_q <= iG_INT2;
            strb_q    <= fall;
            if (fall) begin
                dig_q <= iDIG;
            end
            sum_vld_q <= 1'b0;
            valid_q   <= 1'b0;

            if (iRECAL) begin
                // Takes priority over any strobe in flight; the offset is kept
                // until the next calibration completes.
                state_q    <= ST_WAIT;
                wait_cnt_q <= WAIT_INIT;
            end else begin
                case (state_q)
                    ST_WAIT: begin
                        if (strb_q) begin
                            if (wait_cnt_q <= 16'd1) begin
                                wait_cnt_q <= '0;
                                state_q    <= ST_CAL;
                                cal_acc_q  <= '0;
                                cal_cnt_q  <= CAL_N;
                            end else begin
                                wait_cnt_q <= wait_cnt_q - 16'd1;
                            end
                        end
                    end

                    ST_CAL: begin
                        if (strb_q) begin
                            cal_acc_q <= cal_acc_d;
                            cal_cnt_q <= cal_cnt_q - CCW'(1);
                            if (cal_cnt_q == CCW'(1)) begin
                                state_q  <= ST_RUN;
                                offset_q <= offset_d;
                                for (int i = 0; i < AVG_N; i++) begin
                                    hist_q[i] <= '0;
                                end
                                sum_q <= '0;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (strb_q) begin
                            hist_q[0] <= corr_c;
                            for (int i = 1; i < AVG_N; i++) begin
                                hist_q[i] <= hist_q[i-1];
                            end
                            sum_q     <= sum_d;
                            sum_vld_q <= 1'b1;
                        end
                        if (sum_vld_q) begin
                            level_q <= level_d;
                            led_q   <= led_d;
                            valid_q <= 1'b1;
                        end
                    end

                    default: begin
                        state_q <= ST_WAIT;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------- outputs
    // While settling or calibrating the bar blinks from the wait counter
    // (frozen at zero during calibration, so the bar is dark then).
    assign oLED      = (state_q == ST_RUN) ? led_q : {NLED{wait_cnt_q[BLINK_BIT]}};
    assign oCAL_BUSY = (state_q != ST_RUN);
    assign oLEVEL    = level_q;
    assign oVALID    = valid_q;

endmodule

// File: tb/tb_tilt_led_bar.sv
// -----------------------------------------------------------------------------
// tb_tilt_led_bar
//   Scoreboard bench for tilt_led_bar: RUN strobes push the expected LED/level
//   and due cycle into a queue; a monitor pops and compares on every oVALID.
//   Uses CAL_WAIT=4 and BLINK_BIT=1 so settling is short and the blink visible.
// -----------------------------------------------------------------------------
module tb_tilt_led_bar;

    localparam int DW        = 10;
    localparam int AVG_LOG2  = 4;
    localparam int NLED      = 8;
    localparam int CAL_WAIT  = 4;
    localparam int CAL_LOG2  = 4;
    localparam int DEADZONE  = 16;
    localparam int BLINK_BIT = 1;
    localparam int AVG_N     = 16;
    localparam int CAL_N     = 16;

    localparam int M_WAIT = 0;
    localparam int M_CAL  = 1;
    localparam int M_RUN  = 2;

    logic                 iCLK    = 1'b0;
    logic                 iRSTN   = 1'b0;
    logic [DW-1:0]        iDIG    = '0;
    logic                 iG_INT2 = 1'b1;
    logic                 iRECAL  = 1'b0;
    logic                 iFINE   = 1'b0;
    logic [NLED-1:0]      oLED;
    logic                 oCAL_BUSY;
    logic signed [DW-1:0] oLEVEL;
    logic                 oVALID;

    tilt_led_bar #(
        .DW        (DW),
        .AVG_LOG2  (AVG_LOG2),
        .NLED      (NLED),
        .CAL_WAIT  (CAL_WAIT),
        .CAL_LOG2  (CAL_LOG2),
        .DEADZONE  (DEADZONE),
        .BLINK_BIT (BLINK_BIT)
    ) dut (
        .iCLK      (iCLK),
        .iRSTN     (iRSTN),
        .iDIG      (iDIG),
        .iG_INT2   (iG_INT2),
        .iRECAL    (iRECAL),
        .iFINE     (iFINE),
        .oLED      (oLED),
        .oCAL_BUSY (oCAL_BUSY),
        .oLEVEL    (oLEVEL),
        .oVALID    (oVALID)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    task automatic check(input string tag, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    // ------------------------------------------------------ reference model
    typedef struct {
        logic [7:0] led;
        int         level;
        int         due;
    } exp_t;

    exp_t sb_q[$];

    int m_offset = 0;
    int m_acc    = 0;
    int m_cal_n  = 0;
    int m_sum    = 0;
    int m_hist [AVG_N];

    task automatic model_begin_cal();
        m_acc   = 0;
        m_cal_n = 0;
    endtask

    task automatic model_cal(input int dig);
        int v;
        v = (512 - dig) & 1023;
        if (v >= 512) v = v - 1024;
        m_acc   = m_acc + v;
        m_cal_n = m_cal_n + 1;
        if (m_cal_n == CAL_N) begin
            m_offset = (m_acc >>> 4) & 1023;
            m_sum    = 0;
            for (int i = 0; i < AVG_N; i++) m_hist[i] = 0;
        end
    endtask

    task automatic model_run(input int dig);
        int   c;
        int   avg;
        int   s;
        exp_t e;
        c     = ((dig + m_offset) % 1024) - 512;
        m_sum = m_sum + c - m_hist[AVG_N-1];
        for (int i = AVG_N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = c;
        avg = m_sum >>> 4;
        s   = iFINE ? avg * 4 : avg;
        if (s > 511)  s = 511;
        if (s < -512) s = -512;
        if (s > -DEADZONE && s < DEADZONE) e.led = 8'h18;
        else                               e.led = 8'(1 << (7 - ((s + 512) >> 7)));
        e.level = avg;
        e.due   = cyc + 3;
        sb_q.push_back(e);
    endtask

    // --------------------------------------------------------------- monitor
    always @(negedge iCLK) begin
        if (iRSTN && oVALID) begin
            n_valid++;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_led",     oLED,            e.led);
                check("sb_level",   $signed(oLEVEL), e.level);
                check("sb_latency", cyc,             e.due);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    // Falling edge of iG_INT2 right after a rising clock edge; gap is the
    // number of further cycles before the next strobe may start (min 1).
    task automatic strobe(input int dig, input int mode, input int gap);
        @(posedge iCLK);
        #1;
        iDIG    = dig[DW-1:0];
        iG_INT2 = 1'b0;
        case (mode)
            M_CAL:   model_cal(dig);
            M_RUN:   model_run(dig);
            default: ;
        endcase
        @(posedge iCLK);
        #1;
        iG_INT2 = 1'b1;
        repeat (gap - 1) @(posedge iCLK);
    endtask

    task automatic strobes(input int dig, input int mode, input int n, input int gap);
        for (int i = 0; i < n; i++) strobe(dig, mode, gap);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge iCLK);
            k++;
        end
        repeat (2) @(posedge iCLK);
        #1;
        check("sb_drain", sb_q.size(), 0);
    endtask

    task automatic settle();
        repeat (3) @(posedge iCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0;

        // Reset state
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_led",   oLED,            0);
        check("rst_level", $signed(oLEVEL), 0);
        check("rst_valid", oVALID,          0);
        check("rst_busy",  oCAL_BUSY,       1);
        iRSTN = 1'b1;

        // Settling then calibration with iDIG=0x1F0 -> offset 0x010
        strobes(10'h1F0, M_WAIT, CAL_WAIT, 3);
        settle();
        check("cal_busy",  oCAL_BUSY, 1);
        check("cal_dark",  oLED,      0);
        model_begin_cal();
        strobes(10'h1F0, M_CAL, CAL_N - 1, 3);
        settle();
        check("cal_busy_15", oCAL_BUSY, 1);
        strobe(10'h1F0, M_CAL, 3);
        settle();
        check("cal_done", oCAL_BUSY, 0);

        // Centred input
        strobes(10'h1F0, M_RUN, 16, 3);
        drain();
        check("centre_level", $signed(oLEVEL), 0);
        check("centre_led",   oLED,            8'h18);

        // c=+256, back-to-back strobes, coarse then fine (saturating)
        strobes(10'h2F0, M_RUN, 16, 1);
        drain();
        check("p256_level", $signed(oLEVEL), 256);
        check("p256_led",   oLED,            8'h02);
        iFINE = 1'b1;
        strobe(10'h2F0, M_RUN, 3);
        drain();
        check("p256_fine_led", oLED, 8'h01);

        // Dead-zone boundaries in fine mode: s=+16, +12, -16, -12
        strobes(10'h1F4, M_RUN, 16, 1);
        drain();
        check("dz_p16_led", oLED, 8'h08);
        strobes(10'h1F3, M_RUN, 16, 1);
        drain();
        check("dz_p12_led", oLED, 8'h18);
        strobes(10'h1EC, M_RUN, 16, 1);
        drain();
        check("dz_n16_led", oLED, 8'h10);
        strobes(10'h1ED, M_RUN, 16, 1);
        drain();
        check("dz_n12_led", oLED, 8'h18);

        // c=-200 coarse, then ramp towards 0 by 12.5 per strobe
        iFINE = 1'b0;
        strobe(10'h1ED, M_RUN, 3);
        drain();
        strobes(10'h128, M_RUN, 16, 2);
        drain();
        check("n200_level", $signed(oLEVEL), -200);
        check("n200_led",   oLED,            8'h20);
        strobes(10'h1F0, M_RUN, 8, 2);
        drain();
        check("ramp_level", $signed(oLEVEL), -100);
        check("ramp_led",   oLED,            8'h10);

        // Recalibration coincident with the registered strobe
        nv0 = n_valid;
        @(posedge iCLK);
        #1;
        iDIG    = 10'h1F0;
        iG_INT2 = 1'b0;
        @(posedge iCLK);
        #1;
        iG_INT2 = 1'b1;
        iRECAL  = 1'b1;
        @(posedge iCLK);
        #1;
        iRECAL = 1'b0;
        settle();
        check("recal_no_valid", n_valid,          nv0);
        check("recal_busy",     oCAL_BUSY,        1);
        check("recal_led_c4",   oLED,             8'h00);
        check("recal_level",    $signed(oLEVEL),  -100);

        // Blink follows wait counter bit 1: cnt 3,2 -> on; 1 -> off; CAL -> off
        strobe(10'h1F0, M_WAIT, 3);
        settle();
        check("blink_c3", oLED, 8'hFF);
        strobe(10'h1F0, M_WAIT, 3);
        settle();
        check("blink_c2", oLED, 8'hFF);
        strobe(10'h1F0, M_WAIT, 3);
        settle();
        check("blink_c1", oLED, 8'h00);
        strobe(10'h1F0, M_WAIT, 3);
        settle();
        check("blink_cal", oLED,      8'h00);
        check("blink_busy", oCAL_BUSY, 1);
        model_begin_cal();
        strobes(10'h100, M_CAL, 5, 3);

        // Asynchronous reset mid-calibration
        @(posedge iCLK);
        #3;
        iRSTN = 1'b0;
        #1;
        check("arst_level", $signed(oLEVEL), 0);
        check("arst_valid", oVALID,          0);
        check("arst_led",   oLED,            0);
        check("arst_busy",  oCAL_BUSY,       1);
        @(posedge iCLK);
        #1;
        iRSTN = 1'b1;

        // Full settling is required again: after two strobes cnt=2 blinks on
        strobes(10'h208, M_WAIT, 2, 3);
        settle();
        check("restart_c2", oLED, 8'hFF);
        strobes(10'h208, M_WAIT, 2, 3);
        settle();
        check("restart_cal", oCAL_BUSY, 1);
        model_begin_cal();
        strobes(10'h208, M_CAL, CAL_N, 3);
        settle();
        check("restart_done", oCAL_BUSY, 0);

        // Negative offset (0x3F8): iDIG 0x268 -> c=+96
        strobes(10'h268, M_RUN, 16, 2);
        drain();
        check("p96_level", $signed(oLEVEL), 96);
        check("p96_led",   oLED,            8'h08);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
